// File: rtl/stream_unpack.sv
// Keep-aware downsizer: one wide beat of T_DATA_RATIO words in, kept words out as narrow beats, word 0 first.
// Word 0 appears the cycle after capture; s_ready_o follows m_ready_i on the final word; optional err_o under STREAM_UNPACK_ERR_EN.
module stream_unpack #(
  parameter int T_DATA_WIDTH  = 32,
  parameter int T_DATA_RATIO  = 3,
  parameter int T_WIDTH_RATIO = $clog2(T_DATA_RATIO)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [T_DATA_WIDTH-1:0]  s_data_i [T_DATA_RATIO],
  input  logic [T_WIDTH_RATIO:0]   s_keep_i,
  input  logic                     s_last_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [T_DATA_WIDTH-1:0]  m_data_o,
  output logic                     m_last_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i
`ifdef STREAM_UNPACK_ERR_EN
  ,
  output logic                     err_o
`endif
);

  localparam int KW = T_WIDTH_RATIO + 1;
  localparam logic [KW-1:0] MAX_KEEP = KW'(T_DATA_RATIO);

  logic [T_DATA_WIDTH-1:0]  hold_q [T_DATA_RATIO];
  logic [KW-1:0]            keep_q;
  logic                     last_q;
  logic [T_WIDTH_RATIO-1:0] idx;
  logic                     full;

  logic keep_ok;
  logic last_word;
  logic accept;
  logic m_fire;

  assign keep_ok   = (s_keep_i != '0) && (s_keep_i <= MAX_KEEP);
  assign last_word = ({1'b0, idx} == (keep_q - KW'(1)));

  // Ready depends only on registered state and m_ready_i, never on s_valid_i.
  assign s_ready_o = ~full | (m_ready_i & last_word);
  assign accept    = s_valid_i & s_ready_o;
  assign m_fire    = full & m_ready_i;

  assign m_valid_o = full;
  assign m_last_o  = full & last_q & last_word;
  assign m_data_o  = full ? hold_q[idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        hold_q[i] <= '0;
      end
      keep_q <= '0;
      last_q <= 1'b0;
      idx    <= '0;
      full   <= 1'b0;
    end else if (accept && keep_ok) begin
      // Covers both idle capture and a bubble-free refill on the final word.
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        hold_q[i] <= s_data_i[i];
      end
      keep_q <= s_keep_i;
      last_q <= s_last_i;
      idx    <= '0;
      full   <= 1'b1;
    end else if (m_fire) begin
      if (last_word) begin
        full <= 1'b0;
      end else begin
        idx <= idx + T_WIDTH_RATIO'(1);
      end
    end
  end

`ifdef STREAM_UNPACK_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (accept && !keep_ok) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_unpack.sv
// Directed self-checking bench for stream_unpack (R=3, W=32).
module tb_stream_unpack;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_data [3];
  logic [2:0]  s_keep;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
`ifdef STREAM_UNPACK_ERR_EN
  logic        err;
`endif

  int errs;
  int checks;

  stream_unpack #(
    .T_DATA_WIDTH(32),
    .T_DATA_RATIO(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_keep_i  (s_keep),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
`ifdef STREAM_UNPACK_ERR_EN
    ,
    .err_o     (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic [2:0] keep, input logic last);
    s_data[0] = w0;
    s_data[1] = w1;
    s_data[2] = w2;
    s_keep    = keep;
    s_last    = last;
    s_valid   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    drive_beat(32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    s_valid = 1'b0;
    #12;
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errs++; $display("FAIL reset_m_last got=%b want=0", m_last); end
    checks++; if (m_data !== 32'h0) begin errs++; $display("FAIL reset_m_data got=%h want=0", m_data); end
    checks++; if (s_ready !== 1'b1) begin errs++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
`ifdef STREAM_UNPACK_ERR_EN
    checks++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b want=0", err); end
`endif
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hA000_0000; exp_w[1] = 32'hA000_0001; exp_w[2] = 32'hA000_0002;
    m_ready = 1'b1;
    drive_beat(exp_w[0], exp_w[1], exp_w[2], 3'd3, 1'b1);
    #1;
    checks++; if (s_ready !== 1'b1) begin errs++; $display("FAIL single_idle_ready got=%b want=1", s_ready); end
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m_valid !== 1'b1) begin errs++; $display("FAIL single_valid[%0d] got=%b want=1", i, m_valid); end
      checks++; if (m_data !== exp_w[i]) begin errs++; $display("FAIL single_data[%0d] got=%h want=%h", i, m_data, exp_w[i]); end
      checks++; if (m_last !== (i == 2)) begin errs++; $display("FAIL single_last[%0d] got=%b want=%b", i, m_last, (i == 2)); end
      checks++; if (s_ready !== (i == 2)) begin errs++; $display("FAIL single_ready[%0d] got=%b want=%b", i, s_ready, (i == 2)); end
      step();
    end
    #1;
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL single_drain got=%b want=0", m_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'hB000_0000; exp_w[1] = 32'hB000_0001; exp_w[2] = 32'hB000_0002; exp_w[3] = 32'hC000_0000;
    m_ready = 1'b1;
    drive_beat(exp_w[0], exp_w[1], exp_w[2], 3'd3, 1'b0);
    step();
    drive_beat(exp_w[3], 32'hCCCC_0001, 32'hCCCC_0002, 3'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (m_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid[%0d] got=%b want=1", i, m_valid); end
      checks++; if (m_data !== exp_w[i]) begin errs++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, m_data, exp_w[i]); end
      checks++; if (m_last !== (i == 3)) begin errs++; $display("FAIL b2b_last[%0d] got=%b want=%b", i, m_last, (i == 3)); end
      checks++; if (s_ready !== (i >= 2)) begin errs++; $display("FAIL b2b_ready[%0d] got=%b want=%b", i, s_ready, (i >= 2)); end
      step();
      if (i == 2) s_valid = 1'b0;
    end
    #1;
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got=%b want=0", m_valid); end
  endtask

  task automatic test_partial_keep();
    logic [31:0] exp_w [2];
    exp_w[0] = 32'hD000_0000; exp_w[1] = 32'hD000_0001;
    m_ready = 1'b1;
    drive_beat(exp_w[0], exp_w[1], 32'hDEAD_BEEF, 3'd2, 1'b1);
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (m_data !== exp_w[i]) begin errs++; $display("FAIL keep2_data[%0d] got=%h want=%h", i, m_data, exp_w[i]); end
      checks++; if (m_last !== (i == 1)) begin errs++; $display("FAIL keep2_last[%0d] got=%b want=%b", i, m_last, (i == 1)); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL keep2_extra[%0d] valid=%b data=%h want valid=0", i, m_valid, m_data); end
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_w [3];
    logic        pat [6];
    int          k;
    exp_w[0] = 32'hE000_0000; exp_w[1] = 32'hE000_0001; exp_w[2] = 32'hE000_0002;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
    m_ready = 1'b1;
    drive_beat(exp_w[0], exp_w[1], exp_w[2], 3'd3, 1'b1);
    step();
    s_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      m_ready = pat[c];
      #1;
      checks++; if (m_valid !== 1'b1) begin errs++; $display("FAIL stall_valid[%0d] got=%b want=1", c, m_valid); end
      checks++; if (m_data !== exp_w[k]) begin errs++; $display("FAIL stall_data[%0d] got=%h want=%h", c, m_data, exp_w[k]); end
      checks++; if (m_last !== (k == 2)) begin errs++; $display("FAIL stall_last[%0d] got=%b want=%b", c, m_last, (k == 2)); end
      checks++; if (s_ready !== (pat[c] && k == 2)) begin errs++; $display("FAIL stall_ready[%0d] got=%b want=%b", c, s_ready, (pat[c] && k == 2)); end
      step();
      if (pat[c]) k++;
    end
    m_ready = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL stall_drain got=%b want=0", m_valid); end
  endtask

  task automatic test_illegal_keep();
    m_ready = 1'b1;
    drive_beat(32'hBAD0_0000, 32'hBAD0_0001, 32'hBAD0_0002, 3'd0, 1'b1);
    step();
    drive_beat(32'hBAD1_0000, 32'hBAD1_0001, 32'hBAD1_0002, 3'd4, 1'b1);
    #1;
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL illegal0_valid got=%b want=0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errs++; $display("FAIL illegal0_ready got=%b want=1", s_ready); end
`ifdef STREAM_UNPACK_ERR_EN
    checks++; if (err !== 1'b1) begin errs++; $display("FAIL illegal_err got=%b want=1", err); end
`endif
    step();
    drive_beat(32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 3'd1, 1'b1);
    #1;
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL illegal4_valid got=%b want=0", m_valid); end
    step();
    s_valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b1) begin errs++; $display("FAIL after_illegal_valid got=%b want=1", m_valid); end
    checks++; if (m_data !== 32'hF000_0000) begin errs++; $display("FAIL after_illegal_data got=%h want=f0000000", m_data); end
    checks++; if (m_last !== 1'b1) begin errs++; $display("FAIL after_illegal_last got=%b want=1", m_last); end
    step();
    #1;
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL after_illegal_drain got=%b want=0", m_valid); end
`ifdef STREAM_UNPACK_ERR_EN
    checks++; if (err !== 1'b1) begin errs++; $display("FAIL err_sticky got=%b want=1", err); end
`endif
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    drive_beat(32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 3'd3, 1'b1);
    step();
    s_valid = 1'b0;
    step();
    #1;
    checks++; if (m_data !== 32'h6000_0001) begin errs++; $display("FAIL rstmid_pre_data got=%h want=60000001", m_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid got=%b want=0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errs++; $display("FAIL rstmid_data got=%h want=0", m_data); end
`ifdef STREAM_UNPACK_ERR_EN
    checks++; if (err !== 1'b0) begin errs++; $display("FAIL rstmid_err got=%b want=0", err); end
`endif
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready got=%b want=1", s_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rstmid_leak[%0d] valid=%b data=%h want valid=0", i, m_valid, m_data); end
    end
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_partial_keep();
    test_stall();
    test_illegal_keep();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
